// File: rtl/score_bcd_conv_pkg.sv
// Constants and types shared by the scoring logic, the display path and the
// binary-to-BCD converter.
package slot_pkg;

    localparam int SCORE_W    = 14;
    localparam int NUM_DIGITS = 4;
    localparam int MAX_SCORE  = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // 10^n, used to derive the largest value a DIGITS-wide display can show.
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_bcd_conv_if.sv
// Request/result bundle between the scoring logic (master) and the BCD
// converter (slave).
interface score_bcd_conv_if import slot_pkg::*; #(
    parameter int BIN_W = SCORE_W
);
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             sat;
    logic [3:0]       digit3;
    logic [3:0]       digit2;
    logic [3:0]       digit1;
    logic [3:0]       digit0;

    modport master (
        output start, bin,
        input  busy, done, sat, digit3, digit2, digit1, digit0
    );

    modport slave (
        input  start, bin,
        output busy, done, sat, digit3, digit2, digit1, digit0
    );
endinterface

// File: rtl/score_bcd_conv_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// shift so that the doubled value carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    // Add 3 when the digit would overflow decimal after doubling.
    always_comb begin
        q = (d >= 4'd5) ? (d + 4'd3) : d;
    end
endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digit outputs only change when a conversion completes; out-of-range scores
// display as all nines with sat set.
module score_bcd_conv import slot_pkg::*; #(
    parameter int BIN_W  = SCORE_W,
    parameter int DIGITS = NUM_DIGITS,
    parameter bit AUTO   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    score_bcd_conv_if.slave bus
);
    localparam int          ACC_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W);
    localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);

    conv_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] shreg;
    logic [BIN_W-1:0] last_bin;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] digits_q;
    logic             sat_next;
    logic             sat_q;
    logic             done_q;
    logic             pending;
    logic             trigger;
    logic             load;
    logic             latch;

    // One add-3 correction per accumulator digit, applied before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // A new conversion is wanted on an explicit request, a stored request, or
    // (in auto mode) a score that differs from the one last converted.
    always_comb begin
        trigger = bus.start | pending | (AUTO && (bus.bin != last_bin));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                latch     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers and the displayed result; the result only moves at DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            last_bin <= '0;
            sat_next <= 1'b0;
            pending  <= 1'b0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            digits_q <= '0;
        end else begin
            done_q <= latch;
            if (load) begin
                last_bin <= bus.bin;
                cnt      <= CNT_W'(BIN_W - 1);
                sat_next <= (32'(bus.bin) > MAX_VAL);
                pending  <= 1'b0;
            end else if ((state != IDLE) && bus.start) begin
                pending <= 1'b1;
            end
            if ((state == SHIFT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (latch) begin
                digits_q <= sat_next ? {DIGITS{4'd9}} : acc;
                sat_q    <= sat_next;
            end
        end
    end

    // Shift datapath: high bits leaving the accumulator only occur when the
    // score is already known to saturate, so they are simply dropped.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= bus.bin;
            acc   <= '0;
        end else if (state == SHIFT) begin
            {acc, shreg} <= {acc_adj[ACC_W-2:0], shreg, 1'b0};
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.sat    = sat_q;
    assign bus.digit0 = digits_q[3:0];
    assign bus.digit1 = digits_q[7:4];
    assign bus.digit2 = digits_q[11:8];
    assign bus.digit3 = digits_q[15:12];

endmodule

// File: tb/tb_score_bcd_conv.sv
// Bench for score_bcd_conv: one auto-mode and one start-only instance driven
// side by side and compared every cycle against a transaction-level model.
module tb_score_bcd_conv;
    import slot_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    score_bcd_conv_if #(.BIN_W(SCORE_W)) ifa ();
    score_bcd_conv_if #(.BIN_W(SCORE_W)) ifm ();

    score_bcd_conv #(.BIN_W(SCORE_W), .DIGITS(NUM_DIGITS), .AUTO(1'b1)) u_auto (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    score_bcd_conv #(.BIN_W(SCORE_W), .DIGITS(NUM_DIGITS), .AUTO(1'b0)) u_man (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifm)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state, index 0 = auto instance, 1 = start-only instance.
    int          m_timer [2];
    int          m_val   [2];
    int          m_last  [2];
    bit          m_pend  [2];
    logic [15:0] m_dig   [2];
    bit          m_sat   [2];
    bit          m_done  [2];
    int          dut_done[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > MAX_SCORE) ? MAX_SCORE : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_timer[i] = 0;
            m_val[i]   = 0;
            m_last[i]  = 0;
            m_pend[i]  = 1'b0;
            m_dig[i]   = '0;
            m_sat[i]   = 1'b0;
            m_done[i]  = 1'b0;
        end
    endtask

    // One clock of the model: a conversion occupies SCORE_W+1 cycles, after
    // which the displayed value becomes the captured score (clamped).
    task automatic model_step(input int i, input bit auto_en, input bit st, input int b);
        m_done[i] = 1'b0;
        if (m_timer[i] == 0) begin
            if (st || m_pend[i] || (auto_en && (b != m_last[i]))) begin
                m_val[i]   = b;
                m_last[i]  = b;
                m_pend[i]  = 1'b0;
                m_timer[i] = SCORE_W + 1;
            end
        end else begin
            if (st) m_pend[i] = 1'b1;
            m_timer[i]--;
            if (m_timer[i] == 0) begin
                m_dig[i]  = to_bcd(m_val[i]);
                m_sat[i]  = (m_val[i] > MAX_SCORE);
                m_done[i] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("auto_digits", {ifa.digit3, ifa.digit2, ifa.digit1, ifa.digit0}, m_dig[0]);
        check("auto_sat",    ifa.sat,  m_sat[0]);
        check("auto_done",   ifa.done, m_done[0]);
        check("auto_busy",   ifa.busy, (m_timer[0] != 0));
        check("man_digits",  {ifm.digit3, ifm.digit2, ifm.digit1, ifm.digit0}, m_dig[1]);
        check("man_sat",     ifm.sat,  m_sat[1]);
        check("man_done",    ifm.done, m_done[1]);
        check("man_busy",    ifm.busy, (m_timer[1] != 0));
        if (ifa.done === 1'b1) dut_done[0]++;
        if (ifm.done === 1'b1) dut_done[1]++;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // compare just after it, and return at the falling edge for new stimulus.
    task automatic cycle();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step(0, 1'b1, ifa.start, int'(ifa.bin));
            model_step(1, 1'b0, ifm.start, int'(ifm.bin));
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic man_pulse(input int b);
        ifm.bin   = SCORE_W'(b);
        ifm.start = 1'b1;
        cycle();
        ifm.start = 1'b0;
    endtask

    function automatic logic [SCORE_W-1:0] rand_bin();
        if ($urandom_range(0, 3) == 0) return SCORE_W'($urandom_range(9990, 10010));
        return SCORE_W'($urandom_range(0, 16383));
    endfunction

    initial begin
        int d0;
        reset_n   = 1'b0;
        ifa.start = 1'b0;
        ifa.bin   = '0;
        ifm.start = 1'b0;
        ifm.bin   = '0;
        dut_done[0] = 0;
        dut_done[1] = 0;
        model_reset();
        run(2);
        reset_n = 1'b1;

        // Idle after reset: zero score must not start an auto conversion.
        run(50);
        check("idle_no_done", dut_done[0] + dut_done[1], 0);

        // Plain start-only conversion.
        man_pulse(1234);
        run(20);
        check("man_1234", {ifm.digit3, ifm.digit2, ifm.digit1, ifm.digit0}, 16'h1234);

        // Saturation, then the largest in-range value.
        man_pulse(12000);
        run(20);
        check("man_sat_12000", {ifm.sat, ifm.digit3, ifm.digit2, ifm.digit1, ifm.digit0}, 17'h19999);
        man_pulse(16383);
        run(20);
        check("man_sat_16383", {ifm.sat, ifm.digit3, ifm.digit2, ifm.digit1, ifm.digit0}, 17'h19999);
        man_pulse(9999);
        run(20);
        check("man_9999", {ifm.sat, ifm.digit3, ifm.digit2, ifm.digit1, ifm.digit0}, 17'h09999);

        // Request while busy: one stored re-run that samples the new score.
        d0 = dut_done[1];
        man_pulse(42);
        run(4);
        man_pulse(7);
        run(40);
        check("man_pending_count", dut_done[1] - d0, 2);
        check("man_pending_val", {ifm.digit3, ifm.digit2, ifm.digit1, ifm.digit0}, 16'h0007);

        // Auto tracking of score changes.
        d0 = dut_done[0];
        ifa.bin = SCORE_W'(5);
        run(20);
        check("auto_5", {ifa.digit3, ifa.digit2, ifa.digit1, ifa.digit0}, 16'h0005);
        ifa.bin = SCORE_W'(5);
        run(20);
        ifa.bin = SCORE_W'(100);
        run(20);
        check("auto_100", {ifa.digit3, ifa.digit2, ifa.digit1, ifa.digit0}, 16'h0100);
        check("auto_change_count", dut_done[0] - d0, 2);

        // Reset in the middle of a conversion.
        ifa.bin = SCORE_W'(9876);
        run(7);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst_mid_digits", {ifa.busy, ifa.digit3, ifa.digit2, ifa.digit1, ifa.digit0}, 17'h0);
        @(negedge clk);
        run(3);
        reset_n = 1'b1;
        run(20);
        check("auto_after_rst", {ifa.digit3, ifa.digit2, ifa.digit1, ifa.digit0}, 16'h9876);

        // Randomized traffic on both instances.
        for (int k = 0; k < 600; k++) begin
            ifa.start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) ifa.bin = rand_bin();
            ifm.start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) ifm.bin = rand_bin();
            cycle();
        end
        ifa.start = 1'b0;
        ifm.start = 1'b0;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
